// File: rtl/one_four_demux_reg_pkg.sv
// Shared types and helpers for the 1:4 registered write demux.
// Holds the FSM encoding, slot count and the one-hot slot decode.
package one_four_demux_reg_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [NUM_SLOTS-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/one_four_demux_reg_if.sv
// Write-side bus of the 1:4 demux: input stream handshake plus slot outputs.
interface one_four_demux_reg_if #(parameter int WIDTH = 8);
  import one_four_demux_reg_pkg::*;

  logic [1:0]           sel;
  logic [WIDTH-1:0]     dIn;
  logic                 dInValid;
  logic                 dInReady;
  logic                 startBurst;
  logic [WIDTH-1:0]     dOut0;
  logic [WIDTH-1:0]     dOut1;
  logic [WIDTH-1:0]     dOut2;
  logic [WIDTH-1:0]     dOut3;
  logic [NUM_SLOTS-1:0] wrStrobe;
  logic                 burstDone;

  modport master (
    output sel, dIn, dInValid, startBurst,
    input  dInReady, dOut0, dOut1, dOut2, dOut3, wrStrobe, burstDone
  );

  modport slave (
    input  sel, dIn, dInValid, startBurst,
    output dInReady, dOut0, dOut1, dOut2, dOut3, wrStrobe, burstDone
  );

endinterface

// File: rtl/one_four_demux_reg_slot_decoder.sv
// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module slot_decoder
  import one_four_demux_reg_pkg::*;
(
  input  logic                 en,
  input  logic [1:0]           idx,
  output logic [NUM_SLOTS-1:0] onehot
);

  assign onehot = en ? onehot4(idx) : '0;

endmodule

// File: rtl/one_four_demux_reg.sv
// Routes one input stream into four registered slots, either one write per
// beat (slot from sel) or as a burst with an auto-incrementing slot pointer.
module one_four_demux_reg
  import one_four_demux_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input logic                clk,
  input logic                rst_n,
  one_four_demux_reg_if.slave bus
);

  localparam logic [2:0] LAST = 3'(BURST_LEN);

  state_t                          state;
  logic [1:0]                      ptr;
  logic [2:0]                      cnt;
  logic                            accept;
  logic [1:0]                      wr_idx;
  logic [NUM_SLOTS-1:0]            wr_en;
  logic [NUM_SLOTS-1:0]            wr_strobe;
  logic                            burst_done;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] slot;

  assign bus.dInReady = (state != DONE);
  assign accept       = bus.dInValid && bus.dInReady;
  // Burst beat 0 accepted in IDLE lands on sel, later beats follow the pointer.
  assign wr_idx       = (state == IDLE) ? bus.sel : ptr;

  slot_decoder u_dec (
    .en    (accept),
    .idx   (wr_idx),
    .onehot(wr_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (wr_en[i]) slot[i] <= bus.dIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cnt        <= 3'd0;
      wr_strobe  <= '0;
      burst_done <= 1'b0;
    end else begin
      wr_strobe  <= wr_en;
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.startBurst) begin
            if (bus.dInValid) begin
              ptr <= bus.sel + 2'd1;
              cnt <= 3'd1;
              if (LAST == 3'd1) begin
                state      <= DONE;
                burst_done <= 1'b1;
              end else begin
                state <= BURST;
              end
            end else begin
              ptr   <= bus.sel;
              cnt   <= 3'd0;
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (bus.dInValid) begin
            ptr <= ptr + 2'd1;
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 == LAST) begin
              state      <= DONE;
              burst_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wrStrobe  = wr_strobe;
  assign bus.burstDone = burst_done;
  assign bus.dOut0     = slot[0];
  assign bus.dOut1     = slot[1];
  assign bus.dOut2     = slot[2];
  assign bus.dOut3     = slot[3];

endmodule
